// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arb_pkg
//  Description : Shared widths, FSM state type and command record for the
//                DDR port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_arb_pkg;

    localparam int AMM_ADR_W   = 25;
    localparam int AMM_DATA_W  = 256;
    localparam int AMM_BE_W    = 32;
    localparam int AMM_BURST_W = 7;
    // Wide enough for the largest supported requester count (8)
    localparam int ARB_ID_W    = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [AMM_ADR_W-1:0]  adr;
        logic [AMM_DATA_W-1:0] wdata;
        logic [AMM_BE_W-1:0]   be;
        logic [ARB_ID_W-1:0]   id;
    } arb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ddr_arb_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arb_id_fifo
//  Description : Ordered store of requester ids for reads in flight; push and
//                pop may occur in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_arb_id_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_id_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_id_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign pop_id_o = mem_q[rd_ptr_q];

    assign wr_en = push_i && !full_o;
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Payload needs no reset: entries are only read once counted in
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_port_arbiter
//  Description : Shares one Avalon-MM DDR port among NUM_REQ requesters and
//                routes read beats back in order. Define DDR_ARB_FIXED_PRIO_EN
//                for fixed lowest-index priority instead of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_OUTST = 8
) (
    input  logic                                 CLK_I,
    input  logic                                 RST_N_I,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0][AMM_ADR_W-1:0]    req_adr,
    input  logic [NUM_REQ-1:0][AMM_DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0][AMM_BE_W-1:0]     req_be,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [AMM_DATA_W-1:0]                rsp_rdata,
    output logic                                 err_unexp_rd,
    output logic [AMM_ADR_W-1:0]                 amm_address_0,
    output logic [AMM_DATA_W-1:0]                amm_writedata_0,
    output logic [AMM_BE_W-1:0]                  amm_byteenable_0,
    output logic [AMM_BURST_W-1:0]               amm_burstcount_0,
    output logic                                 amm_read_0,
    output logic                                 amm_write_0,
    input  logic                                 amm_ready_0,
    input  logic                                 amm_readdatavalid_0,
    input  logic [AMM_DATA_W-1:0]                amm_readdata_0
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    arb_state_t              state_q, state_d;
    arb_cmd_t                cmd_q, cmd_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [AMM_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      eligible;
    logic                    grant_any;
    logic [IDW-1:0]          grant_idx;
    logic                    accept;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [IDW-1:0]          fifo_pop_id;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    read_room;
    logic                    id_unused;

    assign id_unused = ^cmd_q.id;

    assign read_room = (fifo_count < CNT_W'(MAX_OUTST));
    assign accept    = (state_q == ISSUE) && amm_ready_0;
    assign fifo_push = accept && !cmd_q.we && !fifo_full;
    assign fifo_pop  = amm_readdatavalid_0 && !fifo_empty;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (req_we[i] || read_room);
        end
    end

`ifdef DDR_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;
    int             rr_idx;

    // Scan downward so the candidate nearest the pointer is assigned last
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            if (eligible[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(rr_idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (cmd_q.id == ARB_ID_W'(NUM_REQ - 1)) ? '0
                                                          : IDW'(cmd_q.id + ARB_ID_W'(1));
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d     = ISSUE;
                    cmd_d.we    = req_we[grant_idx];
                    cmd_d.adr   = req_adr[grant_idx];
                    cmd_d.wdata = req_wdata[grant_idx];
                    cmd_d.be    = req_be[grant_idx];
                    cmd_d.id    = ARB_ID_W'(grant_idx);
                end
            end
            ISSUE: begin
                if (amm_ready_0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q | (amm_readdatavalid_0 & fifo_empty);
        if (fifo_pop) begin
            rsp_rdata_d = amm_readdata_0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (fifo_pop_id == IDW'(i));
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    // Gated with reset so a pending request is not acknowledged while held in reset
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = RST_N_I && (state_q == IDLE) && grant_any && (grant_idx == IDW'(i));
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign err_unexp_rd     = err_q;
    assign amm_address_0    = cmd_q.adr;
    assign amm_writedata_0  = cmd_q.wdata;
    assign amm_byteenable_0 = cmd_q.be;
    assign amm_burstcount_0 = AMM_BURST_W'(1);
    assign amm_read_0       = (state_q == ISSUE) && !cmd_q.we;
    assign amm_write_0      = (state_q == ISSUE) &&  cmd_q.we;

    ddr_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IDW)
    ) u_id_fifo (
        .clk_i     (CLK_I),
        .rst_n_i   (RST_N_I),
        .push_i    (fifo_push),
        .push_id_i (cmd_q.id[IDW-1:0]),
        .pop_i     (fifo_pop),
        .pop_id_o  (fifo_pop_id),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_port_arbiter
//  Description : Directed self-checking bench for ddr_port_arbiter
//                (NUM_REQ=2, MAX_OUTST=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_port_arbiter;

    localparam int NR = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid, req_we;
    logic [NR-1:0][24:0]  req_adr;
    logic [NR-1:0][255:0] req_wdata;
    logic [NR-1:0][31:0]  req_be;
    logic [NR-1:0]        req_ready, rsp_valid;
    logic [255:0]         rsp_rdata;
    logic                 err;
    logic [24:0]          amm_address;
    logic [255:0]         amm_writedata;
    logic [31:0]          amm_byteenable;
    logic [6:0]           amm_burstcount;
    logic                 amm_read, amm_write;
    logic                 amm_ready, amm_rdv;
    logic [255:0]         amm_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  exp_g;
    logic [24:0] exp_a;

    ddr_port_arbiter #(.NUM_REQ(NR), .MAX_OUTST(8)) dut (
        .CLK_I               (clk),
        .RST_N_I             (rst_n),
        .req_valid           (req_valid),
        .req_we              (req_we),
        .req_adr             (req_adr),
        .req_wdata           (req_wdata),
        .req_be              (req_be),
        .req_ready           (req_ready),
        .rsp_valid           (rsp_valid),
        .rsp_rdata           (rsp_rdata),
        .err_unexp_rd        (err),
        .amm_address_0       (amm_address),
        .amm_writedata_0     (amm_writedata),
        .amm_byteenable_0    (amm_byteenable),
        .amm_burstcount_0    (amm_burstcount),
        .amm_read_0          (amm_read),
        .amm_write_0         (amm_write),
        .amm_ready_0         (amm_ready),
        .amm_readdatavalid_0 (amm_rdv),
        .amm_readdata_0      (amm_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [255:0] dat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {8{w}};
    endfunction

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_adr   = '0;
        req_wdata = '0;
        req_be    = '0;
        amm_ready = 1'b0;
        amm_rdv   = 1'b0;
        amm_rdata = '0;

        // Reset values
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_amm_read", amm_read, 0);
        chk("rst_amm_write", amm_write, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_adr", amm_address, 0);
        chk("rst_wdata", amm_writedata, 0);
        chk("rst_be", amm_byteenable, 0);
        chk("rst_burst", amm_burstcount, 1);
        nc();
        rst_n = 1'b1;

        // Single write from req0, accepted immediately
        nc();
        req_valid    = 2'b01;
        req_we       = 2'b01;
        req_adr[0]   = 25'h10;
        req_wdata[0] = {8{32'hA5A5A5A5}};
        req_be[0]    = '1;
        amm_ready    = 1'b1;
        #1 chk("t1_ready", req_ready, 2'b01);
        nc();
        req_valid = '0;
        #1;
        chk("t1_write", amm_write, 1);
        chk("t1_read", amm_read, 0);
        chk("t1_adr", amm_address, 25'h10);
        chk("t1_wdata", amm_writedata, {8{32'hA5A5A5A5}});
        chk("t1_be", amm_byteenable, 32'hFFFFFFFF);
        chk("t1_ready_in_issue", req_ready, 0);
        nc();
        chk("t1_write_once", amm_write, 0);

        // Both requesters continuously valid; pointer now at 1
        req_valid  = 2'b11;
        req_we     = 2'b11;
        req_adr[0] = 25'h20;
        req_adr[1] = 25'h21;
        for (int k = 0; k < 4; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
            exp_a = (exp_g == 2'b01) ? 25'h20 : 25'h21;
            #1 chk("t2_grant", req_ready, exp_g);
            nc();
            chk("t2_adr", amm_address, exp_a);
            chk("t2_write", amm_write, 1);
            nc();
        end
        req_valid = '0;

        // Write stalled by amm_ready low for 5 cycles
        nc();
        amm_ready    = 1'b0;
        req_valid    = 2'b01;
        req_we       = 2'b01;
        req_adr[0]   = 25'h33;
        req_wdata[0] = dat(33);
        req_be[0]    = 32'h0000FFFF;
        #1 chk("t3_ready", req_ready, 2'b01);
        for (int i = 0; i < 6; i++) begin
            nc();
            if (i == 0) begin
                req_valid    = '0;
                req_adr[0]   = 25'h1FFFFFF;
                req_wdata[0] = '0;
                req_be[0]    = '0;
            end
            #1;
            chk("t3_hold_write", amm_write, 1);
            chk("t3_hold_adr", amm_address, 25'h33);
            chk("t3_hold_wdata", amm_writedata, dat(33));
            chk("t3_hold_be", amm_byteenable, 32'h0000FFFF);
            if (i == 5) amm_ready = 1'b1;
        end
        nc();
        chk("t3_single_accept", amm_write, 0);

        // Req1 fills the outstanding-read budget
        req_valid  = 2'b10;
        req_we     = '0;
        req_adr[1] = 25'h100;
        for (int k = 0; k < 8; k++) begin
            #1 chk("t4_rd_grant", req_ready, 2'b10);
            nc();
            chk("t4_read", amm_read, 1);
            nc();
        end
        #1 chk("t4_full_block", req_ready, 0);
        req_valid  = 2'b11;
        req_we     = 2'b01;
        req_adr[0] = 25'h44;
        #1 chk("t4_write_passes", req_ready, 2'b01);
        nc();
        req_valid = 2'b10;
        req_we    = '0;
        chk("t4_write_issue", amm_write, 1);
        nc();
        #1 chk("t4_full_block2", req_ready, 0);
        req_valid = '0;

        // Return 8 beats back-to-back
        for (int i = 0; i < 8; i++) begin
            nc();
            if (i > 0) begin
                chk("t4_rsp_valid", rsp_valid, 2'b10);
                chk("t4_rsp_data", rsp_rdata, dat(i - 1));
            end
            amm_rdv   = 1'b1;
            amm_rdata = dat(i);
        end
        nc();
        chk("t4_rsp_valid_last", rsp_valid, 2'b10);
        chk("t4_rsp_data_last", rsp_rdata, dat(7));
        amm_rdv = 1'b0;
        nc();
        chk("t4_rsp_one_cycle", rsp_valid, 0);
        chk("t4_no_err", err, 0);

        // Unexpected beat with nothing outstanding
        amm_rdv   = 1'b1;
        amm_rdata = dat(99);
        nc();
        amm_rdv = 1'b0;
        nc();
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_err", err, 1);
        chk("t5_rdata_held", rsp_rdata, dat(7));

        // Three reads outstanding, then reset during a stalled write
        req_valid  = 2'b01;
        req_we     = '0;
        req_adr[0] = 25'h200;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t6_rd_grant", req_ready, 2'b01);
            nc();
            nc();
        end
        req_we    = 2'b01;
        amm_ready = 1'b0;
        #1 chk("t6_wr_grant", req_ready, 2'b01);
        nc();
        chk("t6_wr_issue", amm_write, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_write", amm_write, 0);
        chk("t6_rst_read", amm_read, 0);
        chk("t6_rst_adr", amm_address, 0);
        chk("t6_rst_wdata", amm_writedata, 0);
        chk("t6_rst_be", amm_byteenable, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_rdata", rsp_rdata, 0);
        chk("t6_rst_ready", req_ready, 0);
        nc();
        nc();
        req_valid = '0;
        rst_n     = 1'b1;
        nc();
        req_valid  = 2'b10;
        req_we     = 2'b10;
        req_adr[1] = 25'h55;
        amm_ready  = 1'b1;
        #1 chk("t6_req1_grant", req_ready, 2'b10);
        nc();
        req_valid = '0;
        chk("t6_req1_write", amm_write, 1);
        chk("t6_req1_adr", amm_address, 25'h55);
        nc();
        amm_rdv = 1'b1;
        nc();
        amm_rdv = 1'b0;
        nc();
        chk("t6_count_zero_err", err, 1);
        chk("t6_count_zero_rsp", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
